pattern_sweep_gen: RTL and testbench



---
 rtl/pattern_sweep_gen.sv | 137 +++++++++++++
 tb/tb_pattern_sweep_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sweep_gen.sv
// Pattern sweep sequencer: emits every WIDTH-bit pattern (binary count or Galois LFSR) once per sweep.
// Latency: first pattern valid the cycle after start is sampled in IDLE; one pattern per accepted beat.
// Backpressure: out_data/count hold while out_valid && !out_ready; optional checksum via SWEEP_CHECKSUM_EN.
module pattern_sweep_gen #(
  parameter int                WIDTH = 2,
  parameter logic [WIDTH-1:0]  TAPS  = 2'b11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   count,
  output logic [WIDTH-1:0] chk
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 2^WIDTH, the beat count of a full binary sweep
  localparam logic [WIDTH:0] FULL_LEN = {1'b1, {WIDTH{1'b0}}};

  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   r_count;
  logic             r_mode;

  logic             w_fire;
  logic [WIDTH:0]   w_last_idx;
  logic             w_last;
  logic [WIDTH-1:0] w_lfsr;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_first;

  // Beat transfer and end-of-sweep detection; LFSR sweeps skip the all-zero state so are one beat shorter
  assign w_fire     = r_valid && out_ready;
  assign w_last_idx = FULL_LEN - (WIDTH+1)'(1) - {{WIDTH{1'b0}}, r_mode};
  assign w_last     = (r_count == w_last_idx);

  // Galois step: shift right, fold the taps back in when a one falls off the bottom
  assign w_lfsr  = (r_data >> 1) ^ (r_data[0] ? TAPS : '0);
  assign w_next  = r_mode ? w_lfsr : (r_data + WIDTH'(1));
  // A zero seed would lock the LFSR, so it is replaced by 1
  assign w_first = mode ? ((seed == '0) ? WIDTH'(1) : seed) : '0;

  // Sweep control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_count <= '0;
            r_mode  <= mode;
            r_data  <= w_first;
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            r_count <= r_count + (WIDTH+1)'(1);
          end
          if (abort) begin
            // A beat accepted on the abort edge still counts, but the sweep never reports done
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_fire && w_last) begin
            // Last pattern stays on out_data until the next start
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_fire) begin
            r_data <= w_next;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SWEEP_CHECKSUM_EN
  logic [WIDTH-1:0] r_chk;

  // XOR checksum of accepted patterns, cleared when a sweep starts and frozen otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_chk <= '0;
    end else if (r_state == ST_RUN && w_fire) begin
      r_chk <= r_chk ^ r_data;
    end
  end

  assign chk = r_chk;
`else
  assign chk = '0;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = r_count;

endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Self-checking bench for pattern_sweep_gen (WIDTH=2, TAPS=2'b11).
// Expected patterns are queued when a sweep is started and popped as beats are accepted.
// Define SWEEP_CHECKSUM_EN for both bench and RTL to check the checksum build.
module tb_pattern_sweep_gen;

  localparam int               W    = 2;
  localparam logic [W-1:0]     TAPS = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] seed = '0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;
  logic [W:0]   count;
  logic [W-1:0] chk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] model_chk = '0;

  pattern_sweep_gen #(.WIDTH(W), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .done(done), .count(count), .chk(chk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_chk();
`ifdef SWEEP_CHECKSUM_EN
    return model_chk;
`else
    return '0;
`endif
  endfunction

  // Monitor: a beat seen valid&&ready at negedge transfers on the next posedge
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        logic [W-1:0] e;
        e = sb_q.pop_front();
        check("beat_data", out_data, e);
        model_chk = model_chk ^ e;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep and queue its full expected pattern sequence
  task automatic start_sweep(input logic m, input logic [W-1:0] s);
    logic [W-1:0] p;
    int len;
    sb_q.delete();
    model_chk = '0;
    len = m ? (1 << W) - 1 : (1 << W);
    p = m ? ((s == '0) ? W'(1) : s) : '0;
    for (int i = 0; i < len; i++) begin
      sb_q.push_back(p);
      if (m) p = (p >> 1) ^ (p[0] ? TAPS : '0);
      else   p = p + W'(1);
    end
    mode = m;
    seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) tick();
    check("sweep_end_busy", busy, 0);
  endtask

  task automatic finish_checks(input string tag, input int exp_cnt, input logic [W-1:0] last);
    check({tag, "_count"}, count, exp_cnt);
    check({tag, "_valid_low"}, out_valid, 0);
    check({tag, "_data_hold"}, out_data, last);
    check({tag, "_drained"}, sb_q.size(), 0);
    check({tag, "_chk"}, chk, exp_chk());
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    // Reset state
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_chk", chk, 0);
    #10 rst_n = 1'b1;
    tick();

    // Binary count sweep with constant ready
    d0 = done_cnt;
    start_sweep(1'b0, '0);
    check("cnt_first_valid", out_valid, 1);
    check("cnt_first_busy", busy, 1);
    check("cnt_first_data", out_data, 0);
    check("cnt_first_count", count, 0);
    wait_idle();
    tick();
    check("cnt_done_pulses", done_cnt - d0, 1);
    finish_checks("cnt", 4, 2'd3);

    // LFSR sweep seed 1, then seed 0 (replaced by 1)
    d0 = done_cnt;
    start_sweep(1'b1, 2'b01);
    check("lfsr_first_data", out_data, 1);
    wait_idle();
    tick();
    check("lfsr_done_pulses", done_cnt - d0, 1);
    finish_checks("lfsr", 3, 2'd2);

    d0 = done_cnt;
    start_sweep(1'b1, 2'b00);
    check("lfsr0_first_data", out_data, 1);
    wait_idle();
    tick();
    check("lfsr0_done_pulses", done_cnt - d0, 1);
    finish_checks("lfsr0", 3, 2'd2);

    // Backpressure while out_data=1
    d0 = done_cnt;
    start_sweep(1'b0, '0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 1);
      check("bp_count", count, 1);
    end
    out_ready = 1'b1;
    wait_idle();
    tick();
    check("bp_done_pulses", done_cnt - d0, 1);
    finish_checks("bp", 4, 2'd3);

    // Abort after beats 0,1,2; start during RUN ignored
    d0 = done_cnt;
    start_sweep(1'b0, '0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_start_ign_data", out_data, 1);
    check("run_start_ign_count", count, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_count", count, 3);
    check("abort_chk", chk, exp_chk());
    tick();
    tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_count_hold", count, 3);

    // Restart after abort begins at 0 with count 0
    d0 = done_cnt;
    start_sweep(1'b0, '0);
    check("restart_data", out_data, 0);
    check("restart_count", count, 0);
    check("restart_chk", chk, 0);
    wait_idle();
    tick();
    check("restart_done_pulses", done_cnt - d0, 1);
    finish_checks("restart", 4, 2'd3);

    // Abort coinciding with the last LFSR beat: beat counts, no done
    d0 = done_cnt;
    start_sweep(1'b1, 2'b01);
    tick();
    tick();
    check("abl_data", out_data, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tick();
    check("abl_count", count, 3);
    check("abl_no_done", done_cnt - d0, 0);
    check("abl_busy", busy, 0);
    check("abl_drained", sb_q.size(), 0);
    check("abl_chk", chk, exp_chk());

    // Asynchronous reset mid-sweep, between clock edges
    d0 = done_cnt;
    start_sweep(1'b0, '0);
    tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_count", count, 0);
    check("arst_chk", chk, 0);
    sb_q.delete();
    tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("arst_idle_valid", out_valid, 0);
    check("arst_idle_busy", busy, 0);
    check("arst_no_done", done_cnt - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
